// File: rtl/sprite_reg_bank_pkg.sv
// Shared types and sprite word field layout for the sprite register bank.
// The scan FSM state lives here so the top and the sequencer agree on it.
package sprite_reg_bank_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    // Layout of one sprite word as consumed by the renderer.
    localparam int SPR_NUM_LSB = 0;
    localparam int SPR_NUM_MSB = 8;
    localparam int SPR_Y_LSB   = 9;
    localparam int SPR_Y_MSB   = 18;
    localparam int SPR_X_LSB   = 19;
    localparam int SPR_X_MSB   = 28;
    localparam int SPR_USED    = 29;
    localparam int SPR_WORD_W  = 32;

    function automatic logic [SPR_WORD_W-1:0] sprite_pack(
        input logic [SPR_NUM_MSB-SPR_NUM_LSB:0] num,
        input logic [SPR_Y_MSB-SPR_Y_LSB:0]     y,
        input logic [SPR_X_MSB-SPR_X_LSB:0]     x,
        input logic                             used
    );
        sprite_pack                          = '0;
        sprite_pack[SPR_NUM_MSB:SPR_NUM_LSB] = num;
        sprite_pack[SPR_Y_MSB:SPR_Y_LSB]     = y;
        sprite_pack[SPR_X_MSB:SPR_X_LSB]     = x;
        sprite_pack[SPR_USED]                = used;
    endfunction

endpackage

// File: rtl/sprite_reg_bank_scan.sv
// Frame scan sequencer: walks entry indices 0..DEPTH-1 once per scan_start
// and reports when the bank is busy (scanning or holding a deferred commit).
module sprite_reg_bank_scan
    import sprite_reg_bank_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_start,
    input  logic              commit_pending,
    output logic              scan_active,
    output logic [ADDR_W-1:0] scan_idx,
    output logic              scan_last,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // scan_start is only honoured from IDLE; a restart request mid-frame is dropped.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (scan_start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign scan_active = (state_q == SCAN);
    assign scan_idx    = idx_q;
    assign scan_last   = scan_active && (idx_q == LAST_IDX);
    assign busy        = scan_active || commit_pending;

endmodule

// File: rtl/sprite_reg_bank.sv
// Double-buffered sprite register bank: byte-enabled shadow writes, atomic
// frame-boundary publish to the active copy, scan streaming and random read.
module sprite_reg_bank
    import sprite_reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter bit          SHADOW = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic                wr_ack,
    output logic                wr_err,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    input  logic                commit,
    output logic                commit_done,
    input  logic                scan_start,
    output logic                scan_valid,
    output logic [ADDR_W-1:0]   scan_idx,
    output logic [DATA_W-1:0]   scan_data,
    output logic                scan_last,
    output logic                busy
);

    localparam int unsigned     BE_W    = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        be_merge = old_w;
        for (int b = 0; b < int'(BE_W); b++) begin
            if (be[b]) begin
                be_merge[b*8 +: 8] = new_w[b*8 +: 8];
            end
        end
    endfunction

    logic [DATA_W-1:0] shadow_w [DEPTH];
    logic [DATA_W-1:0] active_w [DEPTH];

    logic              wr_in_range;
    logic              rd_in_range;
    logic              scan_active;
    logic              apply_commit;
    logic              pending_q, pending_d;
    logic              wr_ack_q, wr_err_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              commit_done_q;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);

    // A commit that lands mid-frame is deferred until the scan has returned to
    // IDLE so the renderer never sees a half-published frame.
    assign apply_commit = (commit || pending_q) && !scan_active;
    assign pending_d    = (commit || pending_q) && scan_active;

    for (genvar gi = 0; gi < int'(DEPTH); gi++) begin : g_entry
        logic              hit;
        logic [DATA_W-1:0] shadow_q;
        logic [DATA_W-1:0] active_q;
        logic              dirty_q;
        logic [DATA_W-1:0] entry_d;

        assign hit     = wr_en && wr_in_range && (wr_addr == ADDR_W'(gi));
        assign entry_d = be_merge(SHADOW ? shadow_q : active_q, wr_data, wr_be);

        // Write after the commit clear so a same-cycle write leaves the entry dirty.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                shadow_q <= '0;
                active_q <= '0;
                dirty_q  <= 1'b0;
            end else if (SHADOW) begin
                if (apply_commit) begin
                    dirty_q <= 1'b0;
                    if (dirty_q) begin
                        active_q <= shadow_q;
                    end
                end
                if (hit) begin
                    shadow_q <= entry_d;
                    dirty_q  <= 1'b1;
                end
            end else if (hit) begin
                active_q <= entry_d;
            end
        end

        assign shadow_w[gi] = shadow_q;
        assign active_w[gi] = active_q;
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_in_range) begin
            rd_data_d = SHADOW ? shadow_w[rd_addr] : active_w[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ack_q      <= 1'b0;
            wr_err_q      <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            commit_done_q <= 1'b0;
            pending_q     <= 1'b0;
        end else begin
            wr_ack_q      <= wr_en && wr_in_range;
            wr_err_q      <= wr_en && !wr_in_range;
            rd_valid_q    <= rd_en;
            if (rd_en) begin
                rd_data_q <= rd_data_d;
            end
            commit_done_q <= apply_commit;
            pending_q     <= pending_d;
        end
    end

    sprite_reg_bank_scan #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_scan (
        .clk            (clk),
        .reset          (reset),
        .scan_start     (scan_start),
        .commit_pending (pending_q),
        .scan_active    (scan_active),
        .scan_idx       (scan_idx),
        .scan_last      (scan_last),
        .busy           (busy)
    );

    assign wr_ack      = wr_ack_q;
    assign wr_err      = wr_err_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign commit_done = commit_done_q;
    assign scan_valid  = scan_active;
    assign scan_data   = scan_active ? active_w[scan_idx] : '0;

endmodule

// File: tb/tb_sprite_reg_bank.sv
// Directed bench for sprite_reg_bank with DEPTH=36: vector table for the
// write/read path, hand sequences for scan, commit deferral and reset abort.
module tb_sprite_reg_bank;

    localparam int DW    = 32;
    localparam int DEPTH = 36;
    localparam int AW    = 6;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_be;
    logic          wr_ack;
    logic          wr_err;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          commit;
    logic          commit_done;
    logic          scan_start;
    logic          scan_valid;
    logic [AW-1:0] scan_idx;
    logic [DW-1:0] scan_data;
    logic          scan_last;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] act_exp [DEPTH];

    sprite_reg_bank #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .ADDR_W (AW),
        .SHADOW (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .wr_ack      (wr_ack),
        .wr_err      (wr_err),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .commit      (commit),
        .commit_done (commit_done),
        .scan_start  (scan_start),
        .scan_valid  (scan_valid),
        .scan_idx    (scan_idx),
        .scan_data   (scan_data),
        .scan_last   (scan_last),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [3:0]    be;
        logic          re;
        logic [AW-1:0] ra;
        logic          ack;
        logic          err;
        logic          rdv;
        logic [DW-1:0] rdd;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " flags"}, 32'({wr_ack, wr_err, rd_valid, commit_done, scan_valid, scan_last, busy}), 32'd0);
        chk({tag, " rd_data"}, rd_data, 32'd0);
        chk({tag, " scan_data"}, scan_data, 32'd0);
        chk({tag, " scan_idx"}, 32'(scan_idx), 32'd0);
    endtask

    // Runs one full scan; optionally pulses commit or a spurious scan_start at a given index.
    task automatic run_scan(input string tag, input int commit_at, input int restart_at);
        int bad;
        bad = errors;
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            commit     = (i == commit_at);
            scan_start = (i == restart_at);
            chk({tag, " idx"}, 32'(scan_idx), 32'(i));
            chk({tag, " valid/last/busy/done"}, 32'({scan_valid, scan_last, busy, commit_done}),
                32'({1'b1, (i == DEPTH - 1), 1'b1, 1'b0}));
            chk({tag, " data"}, scan_data, act_exp[i]);
            step();
        end
        commit     = 1'b0;
        scan_start = 1'b0;
        chk({tag, " end valid"}, 32'(scan_valid), 32'd0);
        $display("scan %s: %0d words, new errors %0d", tag, DEPTH, errors - bad);
    endtask

    initial begin
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_be      = '0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        commit     = 1'b0;
        scan_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) act_exp[i] = '0;

        //            we  wa      wd            be       re  ra      ack err rdv rdd
        vecs[0]  = '{1'b1, 6'd5,  32'hDEADBEEF, 4'hF,    1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd5,  1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 6'd3,  32'h11223344, 4'hF,    1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 6'd3,  32'hAABBCCDD, 4'b0101, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd3,  1'b0, 1'b0, 1'b1, 32'h11BB33DD};
        vecs[5]  = '{1'b1, 6'd40, 32'hFFFFFFFF, 4'hF,    1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd40, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 6'd9,  32'hCAFEF00D, 4'hF,    1'b1, 6'd9,  1'b1, 1'b0, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd9,  1'b0, 1'b0, 1'b1, 32'hCAFEF00D};
        vecs[9]  = '{1'b1, 6'd5,  32'hFFFFFFFF, 4'h0,    1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd5,  1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[11] = '{1'b1, 6'd35, 32'h12345678, 4'hF,    1'b1, 6'd36, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[12] = '{1'b1, 6'd7,  32'h00000005, 4'b0001, 1'b1, 6'd35, 1'b1, 1'b0, 1'b1, 32'h12345678};
        vecs[13] = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd7,  1'b0, 1'b0, 1'b1, 32'h00000005};

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("in reset");
        @(negedge clk);
        reset = 1'b0;
        step();
        chk_all_zero("after reset");

        for (int v = 0; v < 14; v++) begin
            wr_en   = vecs[v].we;
            wr_addr = vecs[v].wa;
            wr_data = vecs[v].wd;
            wr_be   = vecs[v].be;
            rd_en   = vecs[v].re;
            rd_addr = vecs[v].ra;
            step();
            chk($sformatf("vec%0d ack/err/rdv/done", v),
                32'({wr_ack, wr_err, rd_valid, commit_done}),
                32'({vecs[v].ack, vecs[v].err, vecs[v].rdv, 1'b0}));
            if (vecs[v].rdv) chk($sformatf("vec%0d rd_data", v), rd_data, vecs[v].rdd);
            $display("vec %0d: wr=%0d@%0d rd=%0d@%0d -> ack=%0d err=%0d rdv=%0d rd_data=%h",
                     v, vecs[v].we, vecs[v].wa, vecs[v].re, vecs[v].ra, wr_ack, wr_err, rd_valid, rd_data);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        step();

        // Nothing committed yet: active copy is all zero.
        run_scan("precommit", -1, -1);

        // Commit on scan cycle 2 is deferred to the cycle after scan_last.
        run_scan("deferred", 2, -1);
        chk("deferred T+1 done", 32'(commit_done), 32'd0);
        chk("deferred T+1 busy", 32'(busy), 32'd1);
        step();
        chk("deferred T+2 done", 32'(commit_done), 32'd1);
        chk("deferred T+2 busy", 32'(busy), 32'd0);
        step();
        chk("deferred done pulse", 32'(commit_done), 32'd0);
        act_exp[3]  = 32'h11BB33DD;
        act_exp[5]  = 32'hDEADBEEF;
        act_exp[7]  = 32'h00000005;
        act_exp[9]  = 32'hCAFEF00D;
        act_exp[35] = 32'h12345678;
        run_scan("published", -1, 5);
        chk("published end busy", 32'(busy), 32'd0);

        // Write and commit in the same cycle: active gets the pre-write value.
        wr_en = 1'b1; wr_addr = 6'd2; wr_data = 32'h00000011; wr_be = 4'hF;
        step();
        wr_data = 32'h00000022;
        commit  = 1'b1;
        step();
        wr_en  = 1'b0;
        commit = 1'b0;
        chk("same-cycle ack/done", 32'({wr_ack, commit_done}), 32'b11);
        $display("commit+write entry 2: ack=%0d commit_done=%0d", wr_ack, commit_done);
        step();
        chk("same-cycle done pulse", 32'(commit_done), 32'd0);
        act_exp[2] = 32'h00000011;
        run_scan("old value", -1, -1);
        commit = 1'b1;
        step();
        commit = 1'b0;
        chk("second commit done", 32'(commit_done), 32'd1);
        act_exp[2] = 32'h00000022;
        run_scan("new value", -1, -1);

        // Reset at scan index 10 with a commit pending.
        wr_en = 1'b1; wr_addr = 6'd10; wr_data = 32'h0000ABCD; wr_be = 4'hF;
        step();
        wr_en      = 1'b0;
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            commit = (i == 3);
            if (i < 10) step();
        end
        chk("pre-reset idx", 32'(scan_idx), 32'd10);
        chk("pre-reset busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk_all_zero("mid-scan reset");
        $display("reset asserted at scan index 10 with commit pending");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post-reset cyc%0d done/busy", i), 32'({commit_done, busy}), 32'd0);
        end
        for (int i = 0; i < DEPTH; i++) act_exp[i] = '0;
        rd_en = 1'b1; rd_addr = 6'd10;
        step();
        rd_en = 1'b0;
        chk("post-reset read 10", rd_data, 32'd0);
        run_scan("post-reset", -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_reg_bank.md
# sprite_reg_bank

Parametrised, double-buffered register bank holding per-sprite coordinate/offset words for the video pipeline. The control side writes with byte enables into a shadow copy. A frame-boundary commit atomically publishes the modified entries to the active copy. A scan sequencer streams the active copy to the sprite renderer once per frame, and the bank also provides a registered random-read port.

## Interface
Parameters:
- DATA_W, 32, word width; must be a multiple of 8
- DEPTH, 32, number of entries (need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width
- SHADOW, 1, 1 = writes buffered until commit; 0 = writes go straight to active (commit becomes a no-op pulse)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wr_en  in  1  write request, one word per cycle
- wr_addr  in  ADDR_W  target entry
- wr_data  in  DATA_W  write data
- wr_be  in  DATA_W/8  byte enables
- wr_ack  out  1  registered pulse: write accepted
- wr_err  out  1  registered pulse: wr_addr >= DEPTH, write dropped
- rd_en  in  1  random-read request
- rd_addr  in  ADDR_W  read entry
- rd_data  out  DATA_W  shadow-copy contents (active copy when SHADOW=0)
- rd_valid  out  1  rd_data valid
- commit  in  1  frame-boundary publish request (vsync pulse)
- commit_done  out  1  pulse when publish has been applied
- scan_start  in  1  begin a frame scan of the active copy
- scan_valid  out  1  scan word valid
- scan_idx  out  ADDR_W  entry index of scan word
- scan_data  out  DATA_W  active-copy word
- scan_last  out  1  marks index DEPTH-1
- busy  out  1  scan in progress or commit pending

## Operation
- Reset: both copies, dirty bits, and the commit-pending flag are cleared to 0. Every output is 0; the FSM is in IDLE.
- Write: bytes with wr_be=1 are updated in the shadow copy and the entry's dirty bit is set. Bytes with wr_be=0 keep their previous value. With SHADOW=0, the active copy is written directly.
- Out-of-range write: no state change; wr_err=1 and wr_ack=0.
- Read: an in-range rd_addr returns the stored word. An out-of-range rd_addr returns 0, with rd_valid still asserted.
- Commit:
  - Every dirty entry is copied shadow→active in one cycle, and all dirty bits are cleared.
  - A write in the same cycle as the commit is applied: the commit copies the pre-write shadow value, and that entry's dirty bit ends the cycle set.
- Commit during scan: the commit is latched as pending and applied in the cycle after scan_last, so a frame never sees a mix of old and new data. A second commit while one is already pending merges into it.
- Scan FSM:
  - IDLE --scan_start--> SCAN, with the index at 0.
  - SCAN emits one entry per cycle from 0 to DEPTH-1, then returns to IDLE.
  - scan_start while in SCAN is ignored.

## Timing
- wr_ack/wr_err: 1 cycle after wr_en, 1-cycle pulse.
- rd_data/rd_valid: 1 cycle after rd_en. A write to the same address in the same cycle returns the old data.
- Write to visible in the active copy: the write cycle, then commit, then active is updated at the commit edge.
- commit_done: the cycle after the copy edge.
- First scan_valid: 1 cycle after scan_start. A scan lasts DEPTH cycles and scan_valid is contiguous.
- Reset mid-scan or mid-commit: immediate abort. A pending commit is lost, and no commit_done is issued.

## Structure
- Package sprite_reg_bank_pkg contains:
  - The scan state enum {IDLE, SCAN}.
  - The sprite field localparams: sprite number [8:0], y [18:9], x [28:19], used [29].
- Sub-module sprite_reg_bank_scan holds the FSM, the index counter, and the scan_last/busy generation. The storage and commit logic stay in the top module.

## Test plan
- Reset, then write 0xDEADBEEF to entry 5 with wr_be=4'hF, then read entry 5 → wr_ack is seen 1 cycle later; rd_data=0xDEADBEEF; a scan before any commit shows entry 5 = 0.
- Write 0x11223344 to entry 3, then write 0xAABBCCDD with wr_be=4'b0101 → shadow word is 0x11BB33DD.
- Write to entry 40 with DEPTH=36 → wr_err pulse, no ack; a read of 40 returns 0.
- Write entry 7 = 0x5, scan_start, commit on scan cycle 2 → the whole scan shows entry 7 = 0; commit_done arrives 2 cycles after scan_last; the next scan shows 0x5.
- Commit and a write to entry 2 in the same cycle → the active copy gets the old value; a second commit publishes the new value.
- Assert reset at scan index 10 with a commit pending → all outputs go to 0 immediately; after release, a scan returns all zeros.
